hf_tx_sequencer: RTL and testbench

Sequencer for the HF reader transmit path. It divides the 13.56 MHz carrier clock into the SSP bit clock and frame strobe toward the ARM. It samples `ssp_dout` once per bit and presents a registered modulation bit and depth (full/shallow) to the transmit datapath for exactly one bit period. Frames start, run and stop on clean frame boundaries, so the modulation pattern is never truncated mid-byte.

---
 rtl/hf_tx_pkg.sv | 18 +
 rtl/ssp_bit_timer.sv | 91 +++++++++
 rtl/hf_tx_sequencer.sv | 138 +++++++++++++
 tb/tb_hf_tx_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hf_tx_pkg.sv
// hf_tx_pkg: definitions shared by the HF transmit sequencer and its bit timer.
//   tx_state_t      - sequencer states (IDLE, RUN, STOP)
//   HF_SSP_DIV      - default carrier cycles per half SSP bit period
//   HF_FRAME_BITS   - default bits per SSP frame
//   HF_FRAME_CNT_W  - width of the completed-frame counter
package hf_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } tx_state_t;

    localparam int HF_SSP_DIV     = 16;
    localparam int HF_FRAME_BITS  = 8;
    localparam int HF_FRAME_CNT_W = 16;

endpackage

// File: rtl/ssp_bit_timer.sv
// ssp_bit_timer: divides the carrier into the SSP bit clock and frame strobe.
// Ports:
//   clk, rst_n     - carrier clock, asynchronous active-low reset
//   start          - IDLE->RUN edge: clear counters, raise ssp_frame
//   active         - sequencer is not IDLE; counters run only while set
//   keep_running   - at the frame end, the sequencer stays in RUN
//   rise_pulse     - this edge raises ssp_clk
//   fall_pulse     - this edge lowers ssp_clk and advances the bit counter
//   frame_end      - fall_pulse on the last bit of the frame
//   first_bit      - bit counter is at bit 0
//   ssp_clk        - registered SSP bit clock
//   ssp_frame      - registered frame strobe, high during bit 0
module ssp_bit_timer
    import hf_tx_pkg::*;
#(
    parameter int SSP_DIV    = HF_SSP_DIV,
    parameter int FRAME_BITS = HF_FRAME_BITS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    input  logic keep_running,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic frame_end,
    output logic first_bit,
    output logic ssp_clk,
    output logic ssp_frame
);

    localparam int DIV_W = $clog2(2 * SSP_DIV);
    localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

    localparam logic [DIV_W-1:0] RISE_AT  = DIV_W'(SSP_DIV - 1);
    localparam logic [DIV_W-1:0] FALL_AT  = DIV_W'(2 * SSP_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    logic [DIV_W-1:0] div_cnt_reg;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic             ssp_clk_reg;
    logic             ssp_frame_reg;

    // Strobes are gated by active so nothing fires while the counters sit at 0 in IDLE.
    assign rise_pulse = active && (div_cnt_reg == RISE_AT);
    assign fall_pulse = active && (div_cnt_reg == FALL_AT);
    assign frame_end  = fall_pulse && (bit_cnt_reg == LAST_BIT);
    assign first_bit  = (bit_cnt_reg == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            ssp_clk_reg   <= 1'b0;
            ssp_frame_reg <= 1'b0;
        end else if (start) begin
            // Frame strobe goes up together with the transition so bit 0 is framed.
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            ssp_clk_reg   <= 1'b0;
            ssp_frame_reg <= 1'b1;
        end else if (!active) begin
            div_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            ssp_clk_reg   <= 1'b0;
            ssp_frame_reg <= 1'b0;
        end else begin
            div_cnt_reg <= fall_pulse ? '0 : div_cnt_reg + 1'b1;
            if (rise_pulse) begin
                ssp_clk_reg <= 1'b1;
            end
            if (fall_pulse) begin
                ssp_clk_reg <= 1'b0;
                if (bit_cnt_reg == LAST_BIT) begin
                    bit_cnt_reg   <= '0;
                    // Only frame the next bit 0 if another frame will actually follow.
                    ssp_frame_reg <= keep_running;
                end else begin
                    bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == '0) begin
                        ssp_frame_reg <= 1'b0;
                    end
                end
            end
        end
    end

    assign ssp_clk   = ssp_clk_reg;
    assign ssp_frame = ssp_frame_reg;

endmodule

// File: rtl/hf_tx_sequencer.sv
// hf_tx_sequencer: HF reader transmit sequencer. Generates the SSP bit clock and
// frame strobe from the 13.56 MHz carrier, samples ssp_dout once per bit and
// presents a registered modulation bit/depth. Frames always run to completion.
// Ports:
//   ck_1356meg          - carrier clock
//   rst_n               - asynchronous active-low reset
//   enable              - transmit request
//   shallow_modulation  - requested depth, captured at bit 0 of each frame
//   ssp_dout            - serial data from the ARM, sampled on ssp_clk rise
//   ssp_clk, ssp_frame  - SSP bit clock and frame strobe to the ARM
//   mod_bit             - modulation bit for the current bit period
//   mod_shallow         - depth applied to the current frame
//   tx_active           - high while not IDLE
//   frame_cnt           - completed frames since reset (wraps)
module hf_tx_sequencer
    import hf_tx_pkg::*;
#(
    parameter int SSP_DIV    = HF_SSP_DIV,
    parameter int FRAME_BITS = HF_FRAME_BITS
) (
    input  logic                      ck_1356meg,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      shallow_modulation,
    input  logic                      ssp_dout,
    output logic                      ssp_clk,
    output logic                      ssp_frame,
    output logic                      mod_bit,
    output logic                      mod_shallow,
    output logic                      tx_active,
    output logic [HF_FRAME_CNT_W-1:0] frame_cnt
);

    tx_state_t state_reg;
    tx_state_t state_next;
    logic      start;
    logic      active;
    logic      keep_running;
    logic      rise_pulse;
    logic      fall_pulse;
    logic      frame_end;
    logic      first_bit;

    logic                      mod_bit_reg;
    logic                      mod_shallow_reg;
    logic                      tx_active_reg;
    logic [HF_FRAME_CNT_W-1:0] frame_cnt_reg;

    ssp_bit_timer #(
        .SSP_DIV    (SSP_DIV),
        .FRAME_BITS (FRAME_BITS)
    ) u_timer (
        .clk          (ck_1356meg),
        .rst_n        (rst_n),
        .start        (start),
        .active       (active),
        .keep_running (keep_running),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .frame_end    (frame_end),
        .first_bit    (first_bit),
        .ssp_clk      (ssp_clk),
        .ssp_frame    (ssp_frame)
    );

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // At the frame end the level of enable alone decides between another
    // frame and IDLE, which also covers enable toggling on that very edge.
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = RUN;
                    start      = 1'b1;
                end
            end
            RUN: begin
                if (frame_end) begin
                    state_next = enable ? RUN : IDLE;
                end else if (!enable) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (frame_end) begin
                    state_next = enable ? RUN : IDLE;
                end else if (enable) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign active       = (state_reg != IDLE);
    assign keep_running = (state_next == RUN);

    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            mod_bit_reg     <= 1'b0;
            mod_shallow_reg <= 1'b0;
            tx_active_reg   <= 1'b0;
            frame_cnt_reg   <= '0;
        end else begin
            tx_active_reg <= (state_next != IDLE);
            if (frame_end) begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
            // Leaving for IDLE only happens on the frame-ending fall; the
            // modulator must be quiet from that edge on.
            if (fall_pulse && (state_next == IDLE)) begin
                mod_bit_reg <= 1'b0;
            end else if (rise_pulse) begin
                mod_bit_reg <= ssp_dout;
                if (first_bit) begin
                    mod_shallow_reg <= shallow_modulation;
                end
            end
        end
    end

    assign mod_bit     = mod_bit_reg;
    assign mod_shallow = mod_shallow_reg;
    assign tx_active   = tx_active_reg;
    assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_hf_tx_sequencer.sv
// tb_hf_tx_sequencer: self-checking bench for hf_tx_sequencer with SSP_DIV=4,
// FRAME_BITS=8. A behavioural model tracks time since the frame train started
// and derives every output from modular arithmetic on that time.
module tb_hf_tx_sequencer;

    localparam int D    = 4;
    localparam int FB   = 8;
    localparam int BITP = 2 * D;
    localparam int FRP  = BITP * FB;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        enable  = 1'b0;
    logic        shallow = 1'b0;
    logic        dout    = 1'b0;
    logic        ssp_clk;
    logic        ssp_frame;
    logic        mod_bit;
    logic        mod_shallow;
    logic        tx_active;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    hf_tx_sequencer #(
        .SSP_DIV    (D),
        .FRAME_BITS (FB)
    ) dut (
        .ck_1356meg         (clk),
        .rst_n              (rst_n),
        .enable             (enable),
        .shallow_modulation (shallow),
        .ssp_dout           (dout),
        .ssp_clk            (ssp_clk),
        .ssp_frame          (ssp_frame),
        .mod_bit            (mod_bit),
        .mod_shallow        (mod_shallow),
        .tx_active          (tx_active),
        .frame_cnt          (frame_cnt)
    );

    always #5 clk = ~clk;

    logic [20:0] obs;
    assign obs = {ssp_clk, ssp_frame, mod_bit, mod_shallow, tx_active, frame_cnt};

    // Reference model: m_t = cycles since the start edge of the frame train.
    logic        m_on;
    int          m_t;
    logic        m_mod;
    logic        m_sh;
    logic [15:0] m_fc;
    logic [15:0] fc_bias = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_on  <= 1'b0;
            m_t   <= 0;
            m_mod <= 1'b0;
            m_sh  <= 1'b0;
            m_fc  <= '0;
        end else if (!m_on) begin
            if (enable) begin
                m_on <= 1'b1;
                m_t  <= 0;
            end
        end else begin
            if (m_t % BITP == D - 1) begin
                m_mod <= dout;
                if (m_t % FRP < BITP) m_sh <= shallow;
            end
            if (m_t % FRP == FRP - 1) begin
                m_fc <= m_fc + 16'd1;
                if (!enable) begin
                    m_on  <= 1'b0;
                    m_mod <= 1'b0;
                end
            end
            m_t <= m_t + 1;
        end
    end

    function automatic logic [20:0] exp_vec();
        logic        c;
        logic        f;
        logic [15:0] fc;
        c  = m_on && (m_t % BITP >= D);
        f  = m_on && (m_t % FRP < BITP);
        fc = m_fc + fc_bias;
        return {c, f, m_mod, m_sh, m_on, fc};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        enable  = 1'b0;
        shallow = 1'b0;
        dout    = 1'b0;
        fc_bias = '0;
        @(negedge clk);
        total++;
        if (obs !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", obs, 21'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
        end
        $display("test_reset: idle after reset checked");
    endtask

    task automatic test_pattern();
        logic [7:0] pat;
        int         b;
        int         k;
        pat = 8'hA5;
        do_reset();
        enable = 1'b1;
        dout   = pat[7];
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            b    = (m_t % FRP) / BITP;
            dout = pat[7 - b];
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL pattern_model cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 1) begin
                total++;
                if (tx_active !== 1'b1) begin bad++; $display("FAIL tx_active_c1 got=%b exp=1", tx_active); end
            end
            if (c == 4 || c == 5) begin
                total++;
                if (ssp_clk !== (c == 5)) begin bad++; $display("FAIL first_rise cyc=%0d got=%b exp=%b", c, ssp_clk, c == 5); end
            end
            if (c == 8 || c == 9) begin
                total++;
                if (ssp_frame !== (c == 8)) begin bad++; $display("FAIL frame_width cyc=%0d got=%b exp=%b", c, ssp_frame, c == 8); end
            end
            if (c >= 5 && c <= 68 && ((c - 5) % 8 == 0 || (c - 5) % 8 == 7)) begin
                k = (c - 5) / 8;
                total++;
                if (mod_bit !== pat[7 - k]) begin bad++; $display("FAIL mod_bit_a5 cyc=%0d got=%b exp=%b", c, mod_bit, pat[7 - k]); end
            end
            if (c == 64 || c == 65) begin
                total++;
                if (frame_cnt !== ((c == 65) ? 16'd1 : 16'd0)) begin bad++; $display("FAIL frame_cnt_1 cyc=%0d got=%0d", c, frame_cnt); end
            end
        end
        $display("test_pattern: 0xA5 frame checked");
    endtask

    task automatic test_shallow();
        do_reset();
        enable = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            dout = 1'($urandom);
            if (c == 25) shallow = 1'b1;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL shallow_model cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 68 || c == 69) begin
                total++;
                if (mod_shallow !== (c == 69)) begin bad++; $display("FAIL shallow_frame1 cyc=%0d got=%b exp=%b", c, mod_shallow, c == 69); end
            end
        end
        $display("test_shallow: depth latched at frame boundary checked");
    endtask

    task automatic test_stop();
        do_reset();
        enable = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            dout = 1'($urandom);
            if (c == 17) enable = 1'b0;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL stop_model cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 64) begin
                total++;
                if (tx_active !== 1'b1) begin bad++; $display("FAIL stop_full_frame got=%b exp=1", tx_active); end
            end
            if (c == 65) begin
                total++;
                if ({tx_active, mod_bit, ssp_clk, frame_cnt} !== {3'b000, 16'd1}) begin
                    bad++;
                    $display("FAIL stop_idle got=%b%b%b/%0d exp=000/1", tx_active, mod_bit, ssp_clk, frame_cnt);
                end
            end
        end
        $display("test_stop: frame completed before IDLE checked");
    endtask

    task automatic test_back_to_back();
        do_reset();
        enable = 1'b1;
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            dout = 1'($urandom);
            if (c == 17)  enable = 1'b0;
            if (c == 64)  enable = 1'b1;   // rises exactly at the frame-end edge
            if (c == 80)  enable = 1'b0;
            if (c == 113) enable = 1'b1;   // returns at bit 6
            if (c == 128) enable = 1'b0;   // falls exactly at the frame-end edge
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL b2b_model cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 65 || c == 120) begin
                total++;
                if ({tx_active, ssp_frame} !== {1'b1, c == 65}) begin
                    bad++;
                    $display("FAIL b2b_no_gap cyc=%0d got=%b%b", c, tx_active, ssp_frame);
                end
            end
            if (c == 129) begin
                total++;
                if ({tx_active, mod_bit, frame_cnt} !== {2'b00, 16'd2}) begin
                    bad++;
                    $display("FAIL b2b_edge_idle got=%b%b/%0d exp=00/2", tx_active, mod_bit, frame_cnt);
                end
            end
        end
        $display("test_back_to_back: continuous frames and edge cases checked");
    endtask

    task automatic test_mid_reset();
        do_reset();
        enable = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            dout = 1'($urandom);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL midrst_pre cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs !== 21'd0) begin
            bad++;
            $display("FAIL midrst_async got=%h exp=%h", obs, 21'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            dout = 1'($urandom);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL midrst_post cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 1 || c == 5) begin
                total++;
                if ({ssp_frame, ssp_clk, tx_active} !== {1'b1, c == 5, 1'b1}) begin
                    bad++;
                    $display("FAIL midrst_fresh cyc=%0d got=%b%b%b", c, ssp_frame, ssp_clk, tx_active);
                end
            end
        end
        $display("test_mid_reset: async reset and fresh frame checked");
    endtask

    task automatic test_wrap();
        do_reset();
        enable = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            dout = 1'($urandom);
            if (c == 10) begin
                force dut.frame_cnt_reg = 16'hFFFF;
                #1 release dut.frame_cnt_reg;
                fc_bias = 16'hFFFF - m_fc;
            end
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL wrap_model cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
            if (c == 65) begin
                total++;
                if ({frame_cnt, ssp_frame} !== {16'd0, 1'b1}) begin
                    bad++;
                    $display("FAIL wrap_zero got=%0d/%b exp=0/1", frame_cnt, ssp_frame);
                end
            end
        end
        $display("test_wrap: frame_cnt wrap checked");
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 1; c <= 800; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            dout    = 1'($urandom);
            shallow = 1'($urandom);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", c, obs, exp_vec());
            end
        end
        $display("test_random: randomized enable/data checked");
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_shallow();
        test_stop();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
